differences: RTL and testbench

// - First stage of the SATD datapath: row of 8 pixel residuals, original minus current (predicted) block.
// - Takes 8 unsigned 8-bit ORG samples and 8 unsigned 8-bit CUR samples, packed into two 64-bit words.
// - Produces 8 registered signed 9-bit differences that feed the Hadamard transform stage.

---
 rtl/satd_pkg.sv | 11 +
 rtl/diff_lane.sv | 31 +++
 rtl/differences.sv | 42 ++++
 tb/tb_differences.sv | 120 ++++++++++++
 4 files changed

// File: rtl/satd_pkg.sv
// Shared widths and types for the SATD datapath.
package satd_pkg;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned DIFF_W = 9;
   localparam int unsigned LANES  = 8;

   typedef logic        [PIX_W-1:0]  pix_t;
   typedef logic signed [DIFF_W-1:0] diff_t;

endpackage

// File: rtl/diff_lane.sv
// One residual lane: zero-extended 9-bit subtract followed by an enabled output register.
module diff_lane
   import satd_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  ena,
   input  pix_t  org,
   input  pix_t  cur,
   output diff_t diff
);

   diff_t diff_d;
   diff_t diff_q;

   // Zero-extending both operands keeps the full -255..+255 range without overflow.
   always_comb begin
      diff_d = diff_t'({1'b0, org} - {1'b0, cur});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         diff_q <= '0;
      end else if (ena) begin
         diff_q <= diff_d;
      end
   end

   assign diff = diff_q;

endmodule

// File: rtl/differences.sv
// First SATD stage: eight registered residuals ORG - CUR, one per byte lane.
module differences
   import satd_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic [PIX_W*LANES-1:0] ORG,
   input  logic [PIX_W*LANES-1:0] CUR,
   output diff_t                  diff_0,
   output diff_t                  diff_1,
   output diff_t                  diff_2,
   output diff_t                  diff_3,
   output diff_t                  diff_4,
   output diff_t                  diff_5,
   output diff_t                  diff_6,
   output diff_t                  diff_7
);

   diff_t lane_diff [LANES];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      diff_lane u_diff_lane (
         .clk  (clk),
         .rst  (rst),
         .ena  (ena),
         .org  (ORG[PIX_W*i +: PIX_W]),
         .cur  (CUR[PIX_W*i +: PIX_W]),
         .diff (lane_diff[i])
      );
   end

   assign diff_0 = lane_diff[0];
   assign diff_1 = lane_diff[1];
   assign diff_2 = lane_diff[2];
   assign diff_3 = lane_diff[3];
   assign diff_4 = lane_diff[4];
   assign diff_5 = lane_diff[5];
   assign diff_6 = lane_diff[6];
   assign diff_7 = lane_diff[7];

endmodule

// File: tb/tb_differences.sv
// Randomized self-checking bench for differences against an integer reference model.
module tb_differences;

   logic               clk = 1'b0;
   logic               rst;
   logic               ena;
   logic [63:0]        org;
   logic [63:0]        cur;
   logic signed [8:0]  d [8];

   int checks = 0;
   int errors = 0;
   int model [8];

   differences dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .ORG    (org),
      .CUR    (cur),
      .diff_0 (d[0]),
      .diff_1 (d[1]),
      .diff_2 (d[2]),
      .diff_3 (d[3]),
      .diff_4 (d[4]),
      .diff_5 (d[5]),
      .diff_6 (d[6]),
      .diff_7 (d[7])
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, advance the model, then compare every lane after the edge.
   task automatic step(input string tag, input logic r, input logic e,
                       input logic [63:0] o, input logic [63:0] c);
      logic [7:0] ob;
      logic [7:0] cb;
      rst = r;
      ena = e;
      org = o;
      cur = c;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         ob = o[8*i +: 8];
         cb = c[8*i +: 8];
         if (r) model[i] = 0;
         else if (e) model[i] = int'(ob) - int'(cb);
      end
      #1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s lane%0d", tag, i), int'(d[i]), model[i]);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      int mixed_exp [8];
      logic [63:0] mo;
      logic [63:0] mc;
      logic [63:0] byte_o;
      logic [63:0] byte_c;
      logic [63:0] same;
      mixed_exp = '{-128, 81, -104, -163, -125, 176, 59, -149};
      mo = 64'h36ADEB33333BDB49;
      mc = 64'hCB723BB0D6A38AC9;
      foreach (model[i]) model[i] = 0;

      step("reset0", 1'b1, 1'b1, rnd64(), rnd64());
      step("reset1", 1'b1, 1'b1, rnd64(), rnd64());
      step("post_reset", 1'b0, 1'b1, rnd64(), rnd64());

      step("mixed", 1'b0, 1'b1, mo, mc);
      for (int i = 0; i < 8; i++) check($sformatf("mixed_const lane%0d", i), int'(d[i]), mixed_exp[i]);

      for (int k = 0; k < 3; k++) step("hold", 1'b0, 1'b0, rnd64(), rnd64());
      for (int i = 0; i < 8; i++) check($sformatf("hold_const lane%0d", i), int'(d[i]), mixed_exp[i]);
      step("reenable", 1'b0, 1'b1, rnd64(), rnd64());

      step("max_pos", 1'b0, 1'b1, {8{8'hFF}}, {8{8'h00}});
      for (int i = 0; i < 8; i++) check($sformatf("max_pos_const lane%0d", i), int'(d[i]), 255);
      step("max_neg", 1'b0, 1'b1, {8{8'h00}}, {8{8'hFF}});
      for (int i = 0; i < 8; i++) check($sformatf("max_neg_const lane%0d", i), int'(d[i]), -255);
      same = rnd64();
      step("equal", 1'b0, 1'b1, same, same);

      step("mid", 1'b0, 1'b1, rnd64(), rnd64());
      step("rst_prio", 1'b1, 1'b1, mo, mc);
      for (int i = 0; i < 8; i++) check($sformatf("rst_prio_const lane%0d", i), int'(d[i]), 0);

      for (int k = 0; k < 8; k++) begin
         byte_o = '0;
         byte_c = '0;
         byte_o[8*k +: 8] = 8'h80;
         byte_c[8*k +: 8] = 8'h01;
         step($sformatf("walk%0d", k), 1'b0, 1'b1, byte_o, byte_c);
         for (int i = 0; i < 8; i++) begin
            check($sformatf("walk%0d_const lane%0d", k, i), int'(d[i]), (i == k) ? 127 : 0);
         end
      end

      for (int n = 0; n < 300; n++) begin
         step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), rnd64(), rnd64());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
